// File: rtl/irq_grant_responder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | irq_grant_responder_if : grant-code and CPU id handshake bundle             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface irq_grant_responder_if;
  logic       grant_valid;
  logic [1:0] grant_bus;
  logic [3:0] grant_chan;
  logic       irq_valid;
  logic       irq_ready;
  logic [4:0] irq_id;

  // master: priority encoder plus CPU; slave: the responder
  modport master (
    output grant_valid, grant_bus, grant_chan, irq_ready,
    input  irq_valid, irq_id
  );
  modport slave (
    input  grant_valid, grant_bus, grant_chan, irq_ready,
    output irq_valid, irq_id
  );
endinterface
`default_nettype wire

// File: rtl/irq_grant_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | irq_grant_responder : edge-latching pending store, grant check, CPU         |
// | handshake and one-hot source ack. Optional masking: IRQ_MASK_EN.            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module irq_grant_responder #(
  parameter int N_CH        = 9,
  parameter int HOLD_CYCLES = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [N_CH-1:0] req_a,
  input  wire logic [N_CH-1:0] req_b,
  input  wire logic [N_CH-1:0] req_c,
`ifdef IRQ_MASK_EN
  input  wire logic [N_CH-1:0] mask_a,
  input  wire logic [N_CH-1:0] mask_b,
  input  wire logic [N_CH-1:0] mask_c,
`endif
  output logic [N_CH-1:0]      pend_a,
  output logic [N_CH-1:0]      pend_b,
  output logic [N_CH-1:0]      pend_c,
  output logic [N_CH-1:0]      ack_a,
  output logic [N_CH-1:0]      ack_b,
  output logic [N_CH-1:0]      ack_c,
  output logic                 err_code,
  irq_grant_responder_if.slave gif
);

  localparam int NT = 3 * N_CH;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_PRESENT = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NT-1:0]   req_prev_q, req_prev_d;
  logic [NT-1:0]   pending_q, pending_d;
  logic [NT-1:0]   ack_q, ack_d;
  logic [1:0]      bus_q, bus_d;
  logic [3:0]      chan_q, chan_d;
  logic [4:0]      id_q, id_d;
  logic            valid_q, valid_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [NT-1:0]   req_flat;
  logic [NT-1:0]   mask_flat;
  logic [NT-1:0]   pend_flat;
  logic [NT-1:0]   ack_clr;
  logic [31:0]     pend_ext;
  logic [4:0]      bus_m1;
  logic [4:0]      cand_id;
  logic            code_ok;

  assign req_flat = {req_c, req_b, req_a};
`ifdef IRQ_MASK_EN
  assign mask_flat = {mask_c, mask_b, mask_a};
`else
  assign mask_flat = '0;
`endif
  assign pend_flat = pending_q & ~mask_flat;
  assign pend_ext  = 32'(pend_flat);

  assign {pend_c, pend_b, pend_a} = pend_flat;
  assign {ack_c, ack_b, ack_a}    = ack_q;
  assign gif.irq_valid            = valid_q;
  assign gif.irq_id               = id_q;

  // Flat index of bus/chan equals the CPU id; a bus-0 code wraps high and is gated by code_ok
  assign bus_m1  = {3'b000, bus_q} - 5'd1;
  assign cand_id = bus_m1 * 5'(N_CH) + {1'b0, chan_q};
  assign code_ok = (bus_q != 2'd0) && (int'(chan_q) < N_CH) && pend_ext[cand_id];

  // Only the first ack cycle clears; a fresh rise in that cycle is OR-ed in afterwards and wins
  assign ack_clr = (state_q == S_ACK && hold_q == '0) ? ack_q : '0;

  always_comb begin
    req_prev_d = req_flat;
    pending_d  = (pending_q & ~ack_clr) | (req_flat & ~req_prev_q);
    state_d    = state_q;
    bus_d      = bus_q;
    chan_d     = chan_q;
    id_d       = id_q;
    valid_d    = valid_q;
    ack_d      = ack_q;
    hold_d     = hold_q;
    err_code   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gif.grant_valid && (|pend_flat)) begin
          bus_d   = gif.grant_bus;
          chan_d  = gif.grant_chan;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (code_ok) begin
          id_d    = cand_id;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end else begin
          err_code = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_PRESENT: begin
        if (gif.irq_ready) begin
          valid_d = 1'b0;
          ack_d   = {{(NT-1){1'b0}}, 1'b1} << id_q;
          hold_d  = '0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          ack_d   = '0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_prev_q <= '0;
      pending_q  <= '0;
      ack_q      <= '0;
      bus_q      <= '0;
      chan_q     <= '0;
      id_q       <= '0;
      valid_q    <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      bus_q      <= bus_d;
      chan_q     <= chan_d;
      id_q       <= id_d;
      valid_q    <= valid_d;
      hold_q     <= hold_d;
    end
  end

endmodule
`default_nettype wire
